// File: rtl/single_port_ram_pads_if.sv
// Control/address pad bundle for the single-port RAM pad ring.
// The bidirectional data pad stays a plain inout port on the top level.
interface single_port_ram_pads_if #(
   parameter int ADDRWIDTH = 4
);
   logic [ADDRWIDTH-1:0] addr_pad;
   logic                 cs_pad;
   logic                 we_pad;
   logic                 oe_pad;

   modport master (output addr_pad, cs_pad, we_pad, oe_pad);
   modport slave  (input  addr_pad, cs_pad, we_pad, oe_pad);
endinterface

// File: rtl/single_port_ram_pads.sv
// Synchronous single-port SRAM behind a pad ring: buffered inputs and a
// tri-state data pad driven with the registered read word.
module single_port_ram_pads #(
   parameter int ADDRWIDTH = 4,
   parameter int DATAWIDTH = 8,
   parameter int SIZE      = 16
) (
   input  logic                        clk_pad,
   input  logic                        rst_pad,
   single_port_ram_pads_if.slave       pads,
   inout  wire  [DATAWIDTH-1:0]        data_pad
);

   logic                 clk;
   logic                 rst;
   logic [ADDRWIDTH-1:0] addr;
   logic                 cs;
   logic                 we;
   logic                 oe;
   logic [DATAWIDTH-1:0] wr_data;
   logic [DATAWIDTH-1:0] rd_q;
   logic                 drv_en;
   logic                 in_range;
   logic [DATAWIDTH-1:0] mem [SIZE];

   assign clk     = clk_pad;
   assign rst     = rst_pad;
   assign addr    = pads.addr_pad;
   assign cs      = pads.cs_pad;
   assign we      = pads.we_pad;
   assign oe      = pads.oe_pad;
   assign wr_data = data_pad;

   assign in_range = int'(addr) < SIZE;
   assign drv_en   = cs & oe & ~we;

   // Pad output depends only on rd_q and enables, never on the pad input.
   assign data_pad = drv_en ? rd_q : 'z;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
         for (int i = 0; i < SIZE; i++) begin
            mem[i] <= '0;
         end
      end else if (cs) begin
         if (we) begin
            if (in_range) begin
               mem[addr] <= wr_data;
            end
         end else begin
            rd_q <= in_range ? mem[addr] : '0;
         end
      end
   end

endmodule

// File: tb/tb_single_port_ram_pads.sv
// Scoreboard bench for single_port_ram_pads: reads push expected words,
// which are popped and compared once the registered read reaches the pad.
module tb_single_port_ram_pads;

   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int SIZE = 16;

   logic          clk_pad = 1'b0;
   logic          rst_pad;
   logic          tb_drv;
   logic [DW-1:0] tb_data;
   wire  [DW-1:0] data_pad;

   logic [DW-1:0] model [SIZE];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_v;

   int total = 0;
   int bad   = 0;

   single_port_ram_pads_if #(.ADDRWIDTH(AW)) pads ();

   single_port_ram_pads #(
      .ADDRWIDTH(AW),
      .DATAWIDTH(DW),
      .SIZE     (SIZE)
   ) dut (
      .clk_pad (clk_pad),
      .rst_pad (rst_pad),
      .pads    (pads.slave),
      .data_pad(data_pad)
   );

   assign data_pad = tb_drv ? tb_data : 'z;

   always #5 clk_pad = ~clk_pad;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_pad);
      #1;
   endtask

   task automatic set_bus(input logic cs, input logic we, input logic oe,
                          input logic [AW-1:0] a);
      pads.cs_pad   = cs;
      pads.we_pad   = we;
      pads.oe_pad   = oe;
      pads.addr_pad = a;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      set_bus(1'b1, 1'b1, 1'b0, a);
      tb_drv  = 1'b1;
      tb_data = d;
      tick();
      model[a] = d;
      tb_drv   = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input string tag);
      set_bus(1'b1, 1'b0, 1'b1, a);
      tb_drv = 1'b0;
      exp_q.push_back(model[a]);
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (data_pad !== exp_v) begin
         bad++;
         $display("FAIL %s addr=%0d got=%h want=%h", tag, a, data_pad, exp_v);
      end
   endtask

   task automatic test_reset();
      rst_pad = 1'b1;
      set_bus(1'b1, 1'b0, 1'b1, '0);
      tick();
      rst_pad = 1'b0;
      total++;
      if (data_pad !== 8'h00) begin
         bad++;
         $display("FAIL reset_rd_q got=%h want=00", data_pad);
      end
      for (int i = 0; i < SIZE; i++) model[i] = '0;
      for (int i = 0; i < SIZE; i++) do_read(AW'(i), "reset_read");
   endtask

   task automatic test_fill_readback();
      for (int i = 0; i < SIZE; i++) do_write(AW'(i), 8'($urandom_range(255, 1)));
      for (int i = 0; i < SIZE; i++) do_read(AW'(i), "fill_read");
   endtask

   task automatic test_overwrite();
      do_write(4'd3, 8'hA5);
      do_write(4'd3, 8'h5A);
      do_read(4'd3, "last_write_wins");
   endtask

   task automatic test_cs_idle();
      // rd_q holds 0x5A here, so any DUT drive would disturb the probe value.
      set_bus(1'b0, 1'b1, 1'b0, 4'd2);
      tb_drv  = 1'b1;
      tb_data = 8'hFF;
      tick();
      set_bus(1'b0, 1'b0, 1'b1, 4'd2);
      tb_data = 8'h00;
      tick();
      total++;
      if (data_pad !== 8'h00) begin
         bad++;
         $display("FAIL idle_bus_released got=%h want=00", data_pad);
      end
      tb_drv = 1'b0;
      do_read(4'd2, "cs0_no_write");
   endtask

   task automatic test_no_contention();
      set_bus(1'b1, 1'b1, 1'b1, 4'd9);
      tb_drv  = 1'b1;
      tb_data = 8'h00;
      #1;
      total++;
      if (data_pad !== 8'h00) begin
         bad++;
         $display("FAIL write_oe_bus got=%h want=00", data_pad);
      end
      tick();
      model[9] = 8'h00;

      set_bus(1'b1, 1'b0, 1'b0, 4'd5);
      exp_q.push_back(model[5]);
      tick();
      total++;
      if (data_pad !== 8'h00) begin
         bad++;
         $display("FAIL read_oe0_bus_released got=%h want=00", data_pad);
      end
      tb_drv = 1'b0;

      set_bus(1'b1, 1'b0, 1'b1, 4'd9);
      #1;
      exp_v = exp_q.pop_front();
      total++;
      if (data_pad !== exp_v) begin
         bad++;
         $display("FAIL rd_q_updated_oe0 got=%h want=%h", data_pad, exp_v);
      end
      exp_q.push_back(model[9]);
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (data_pad !== exp_v) begin
         bad++;
         $display("FAIL write_with_oe_stored got=%h want=%h", data_pad, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < SIZE; i++) do_write(AW'(i), 8'(8'h3C ^ i) | 8'h01);
      do_read(4'd7, "prefill_read");
      rst_pad = 1'b1;
      set_bus(1'b1, 1'b1, 1'b0, 4'd7);
      tb_drv  = 1'b1;
      tb_data = 8'h77;
      tick();
      rst_pad = 1'b0;
      tb_drv  = 1'b0;
      for (int i = 0; i < SIZE; i++) model[i] = '0;
      do_read(4'd7, "reset_mid_read7");
      do_read(4'd0, "reset_mid_read0");
      do_read(4'd15, "reset_mid_read15");
   endtask

   initial begin
      rst_pad = 1'b1;
      tb_drv  = 1'b0;
      tb_data = '0;
      set_bus(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk_pad);
      test_reset();
      test_fill_readback();
      test_overwrite();
      test_cs_idle();
      test_no_contention();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
